ddr_capture_writer: RTL and testbench



---
 rtl/ddr_capture_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_ddr_capture_writer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_capture_writer.sv
// Drains the pre-DDR FIFO into DDR3 through the MIG native write interface, one command and one data beat per word.
// Build option: define DDR_WRITER_WRAP_EN to wrap at the depth limit (circular buffer) instead of stopping in FULL.
module ddr_capture_writer #(
    parameter int ADDR_WIDTH  = 30,
    parameter int COUNT_WIDTH = 27,
    parameter int ADDR_INC    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   capture_start,
    input  logic                   capture_done,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [COUNT_WIDTH-1:0] max_words,
    input  logic [63:0]            fifo_dout,
    input  logic                   fifo_empty,
    output logic                   fifo_rd,
    output logic [ADDR_WIDTH-1:0]  app_addr,
    output logic [2:0]             app_cmd,
    output logic                   app_en,
    input  logic                   app_rdy,
    output logic [63:0]            app_wdf_data,
    output logic                   app_wdf_wren,
    output logic                   app_wdf_end,
    input  logic                   app_wdf_rdy,
    output logic [COUNT_WIDTH-1:0] words_written,
    output logic                   busy,
    output logic                   write_done,
    output logic                   mem_full
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(ADDR_INC);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [COUNT_WIDTH-1:0] limit_q, limit_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;
    logic [63:0]            hold_data_q, hold_data_d;
    logic                   hold_valid_q, hold_valid_d;
    logic                   cmd_ok_q, cmd_ok_d;
    logic                   dat_ok_q, dat_ok_d;
    logic                   done_pend_q, done_pend_d;
    logic                   mem_full_q, mem_full_d;

    logic                   in_run;
    logic                   cmd_acc;
    logic                   dat_acc;
    logic                   word_complete;
    logic [COUNT_WIDTH-1:0] words_inc;
    logic                   limit_hit_next;
    logic                   done_event;
    logic                   pop;

    // Handshake decode: both MIG channels complete independently; a word retires once both have.
    always_comb begin
        in_run         = (state_q == ST_RUN);
        cmd_acc        = app_en & app_rdy;
        dat_acc        = app_wdf_wren & app_wdf_rdy;
        word_complete  = hold_valid_q & (cmd_ok_q | cmd_acc) & (dat_ok_q | dat_acc);
        words_inc      = words_q + COUNT_WIDTH'(word_complete);
        limit_hit_next = (limit_q != '0) && (words_inc == limit_q);
        done_event     = (capture_done | done_pend_q) & (~hold_valid_q | word_complete);
        pop            = fifo_rd & in_run;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start wins over done, enable wins over everything.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (capture_start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (done_event) begin
                        state_d = ST_DONE;
                    end else if (word_complete && limit_hit_next) begin
`ifdef DDR_WRITER_WRAP_EN
                        state_d = ST_RUN;
`else
                        state_d = ST_FULL;
`endif
                    end
                end
                ST_FULL: begin
                    if (capture_done) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: only fifo_rd looks at the MIG ready inputs; the rest decode flops.
    always_comb begin
        fifo_rd      = 1'b0;
        app_en       = hold_valid_q & ~cmd_ok_q;
        app_wdf_wren = hold_valid_q & ~dat_ok_q;
        busy         = (state_q == ST_RUN) || (state_q == ST_FULL);
        write_done   = (state_q == ST_DONE);
        if (enable && !capture_start && !fifo_empty) begin
            if (state_q == ST_RUN) begin
                fifo_rd = (~hold_valid_q | word_complete) & ~limit_hit_next;
            end else if (state_q == ST_FULL) begin
                fifo_rd = 1'b1;
            end
        end
    end

    assign app_cmd       = 3'b000;
    assign app_addr      = addr_q;
    assign app_wdf_data  = hold_data_q;
    assign app_wdf_end   = app_wdf_wren;
    assign words_written = words_q;
    assign mem_full      = mem_full_q;

    // Datapath next-state: holding register, address/count, sticky flags.
    always_comb begin
        addr_d       = addr_q;
        base_d       = base_q;
        limit_d      = limit_q;
        words_d      = words_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        cmd_ok_d     = cmd_ok_q;
        dat_ok_d     = dat_ok_q;
        done_pend_d  = done_pend_q;
        mem_full_d   = mem_full_q;

        if (!enable) begin
            hold_valid_d = 1'b0;
            cmd_ok_d     = 1'b0;
            dat_ok_d     = 1'b0;
            done_pend_d  = 1'b0;
        end else if (capture_start) begin
            addr_d       = start_addr;
            base_d       = start_addr;
            limit_d      = max_words;
            words_d      = '0;
            mem_full_d   = 1'b0;
            hold_valid_d = 1'b0;
            cmd_ok_d     = 1'b0;
            dat_ok_d     = 1'b0;
            done_pend_d  = 1'b0;
        end else if (in_run) begin
            if (word_complete) begin
                addr_d       = addr_q + ADDR_STEP;
                words_d      = words_inc;
                hold_valid_d = 1'b0;
                cmd_ok_d     = 1'b0;
                dat_ok_d     = 1'b0;
                if (limit_hit_next) begin
                    mem_full_d = 1'b1;
`ifdef DDR_WRITER_WRAP_EN
                    addr_d     = base_q;
                    words_d    = '0;
`endif
                end
            end else begin
                cmd_ok_d = cmd_ok_q | cmd_acc;
                dat_ok_d = dat_ok_q | dat_acc;
            end
            if (pop) begin
                hold_data_d  = fifo_dout;
                hold_valid_d = 1'b1;
                cmd_ok_d     = 1'b0;
                dat_ok_d     = 1'b0;
            end
            done_pend_d = done_pend_q | (capture_done & hold_valid_q);
            if (done_event) done_pend_d = 1'b0;
        end else begin
            hold_valid_d = 1'b0;
            cmd_ok_d     = 1'b0;
            dat_ok_d     = 1'b0;
            done_pend_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: hold_data drives app_wdf_data directly, so it is reset like every other output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            base_q       <= '0;
            limit_q      <= '0;
            words_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            cmd_ok_q     <= 1'b0;
            dat_ok_q     <= 1'b0;
            done_pend_q  <= 1'b0;
            mem_full_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            base_q       <= base_d;
            limit_q      <= limit_d;
            words_q      <= words_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            cmd_ok_q     <= cmd_ok_d;
            dat_ok_q     <= dat_ok_d;
            done_pend_q  <= done_pend_d;
            mem_full_q   <= mem_full_d;
        end
    end

endmodule

// File: tb/tb_ddr_capture_writer.sv
// Directed bench for ddr_capture_writer: FWFT FIFO model, MIG acceptance logger, hand-computed expectations.
// Define DDR_WRITER_WRAP_EN for both files to exercise the wrapping build instead of the FULL-stop build.
module tb_ddr_capture_writer;

    localparam int AW = 30;
    localparam int CW = 27;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          capture_start;
    logic          capture_done;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] max_words;
    logic [63:0]   fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [63:0]   app_wdf_data;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [CW-1:0] words_written;
    logic          busy;
    logic          write_done;
    logic          mem_full;

    int checks = 0;
    int errors = 0;

    logic [63:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic [63:0] cmd_addr_log [0:63];
    logic [63:0] dat_log      [0:63];
    int          cmd_cyc      [0:63];
    int          cmd_n = 0;
    int          dat_n = 0;
    int          cyc   = 0;

    ddr_capture_writer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .ADDR_INC(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .capture_start (capture_start),
        .capture_done  (capture_done),
        .start_addr    (start_addr),
        .max_words     (max_words),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd       (fifo_rd),
        .app_addr      (app_addr),
        .app_cmd       (app_cmd),
        .app_en        (app_en),
        .app_rdy       (app_rdy),
        .app_wdf_data  (app_wdf_data),
        .app_wdf_wren  (app_wdf_wren),
        .app_wdf_end   (app_wdf_end),
        .app_wdf_rdy   (app_wdf_rdy),
        .words_written (words_written),
        .busy          (busy),
        .write_done    (write_done),
        .mem_full      (mem_full)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = fifo_mem[rd_ptr % 64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd && !fifo_empty) rd_ptr <= rd_ptr + 1;
        if (reset_n && app_en && app_rdy) begin
            cmd_addr_log[cmd_n % 64] <= 64'(app_addr);
            cmd_cyc[cmd_n % 64]      <= cyc;
            cmd_n                    <= cmd_n + 1;
        end
        if (reset_n && app_wdf_wren && app_wdf_rdy) begin
            dat_log[dat_n % 64] <= app_wdf_data;
            dat_n               <= dat_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] d);
        fifo_mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a, input logic [CW-1:0] m);
        start_addr    = a;
        max_words     = m;
        capture_start = 1'b1;
        @(negedge clk);
        capture_start = 1'b0;
    endtask

    task automatic pulse_done();
        capture_done = 1'b1;
        @(negedge clk);
        capture_done = 1'b0;
    endtask

    task automatic wait_cmds(input int target);
        for (int i = 0; i < 40 && cmd_n < target; i++) @(negedge clk);
    endtask

    int b;
    int bd;

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        capture_start = 1'b0;
        capture_done  = 1'b0;
        start_addr    = '0;
        max_words     = '0;
        app_rdy       = 1'b0;
        app_wdf_rdy   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_addr", 64'(app_addr), 64'h0);
        check("rst_en", 64'(app_en), 64'h0);
        check("rst_wren", 64'(app_wdf_wren), 64'h0);
        check("rst_cmd", 64'(app_cmd), 64'h0);
        check("rst_words", 64'(words_written), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_wdone", 64'(write_done), 64'h0);
        check("rst_full", 64'(mem_full), 64'h0);
        reset_n = 1'b1;
        enable  = 1'b1;
        @(negedge clk);

        // Basic write: four words back to back, MIG always ready
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i));
        b  = cmd_n;
        bd = dat_n;
        pulse_start(30'h100, 27'd0);
        check("basic_busy", 64'(busy), 64'h1);
        wait_cmds(b + 4);
        repeat (2) @(negedge clk);
        check("basic_ncmd", 64'(cmd_n - b), 64'd4);
        check("basic_ndat", 64'(dat_n - bd), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_addr%0d", i), cmd_addr_log[(b + i) % 64], 64'h100 + 64'(8 * i));
            check($sformatf("basic_data%0d", i), dat_log[(bd + i) % 64], 64'hA0 + 64'(i));
        end
        check("basic_b2b", 64'(cmd_cyc[(b + 3) % 64] - cmd_cyc[b % 64]), 64'd3);
        check("basic_words", 64'(words_written), 64'd4);
        pulse_done();
        check("basic_wdone", 64'(write_done), 64'h1);
        check("basic_words_done", 64'(words_written), 64'd4);
        @(negedge clk);
        check("basic_wdone_1cyc", 64'(write_done), 64'h0);
        check("basic_idle", 64'(busy), 64'h0);

        // Handshake skew: command ready low while data ready high
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b1;
        push(64'hB0);
        push(64'hB1);
        b  = cmd_n;
        bd = dat_n;
        pulse_start(30'h200, 27'd0);
        #1 check("skew_pop0", 64'(fifo_rd), 64'h1);
        @(negedge clk);
        check("skew_en", 64'(app_en), 64'h1);
        check("skew_wren", 64'(app_wdf_wren), 64'h1);
        check("skew_wend", 64'(app_wdf_end), 64'h1);
        check("skew_nopop", 64'(fifo_rd), 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("skew_en_hold%0d", k), 64'(app_en), 64'h1);
            check($sformatf("skew_wren_off%0d", k), 64'(app_wdf_wren), 64'h0);
            check($sformatf("skew_addr%0d", k), 64'(app_addr), 64'h200);
            check($sformatf("skew_data%0d", k), app_wdf_data, 64'hB0);
            check($sformatf("skew_stall%0d", k), 64'(fifo_rd), 64'h0);
        end
        app_rdy = 1'b1;
        #1 check("skew_pop1", 64'(fifo_rd), 64'h1);
        wait_cmds(b + 2);
        repeat (2) @(negedge clk);
        check("skew_ncmd", 64'(cmd_n - b), 64'd2);
        check("skew_ndat", 64'(dat_n - bd), 64'd2);
        check("skew_a1", cmd_addr_log[(b + 1) % 64], 64'h208);
        check("skew_d0", dat_log[bd % 64], 64'hB0);
        check("skew_d1", dat_log[(bd + 1) % 64], 64'hB1);
        check("skew_words", 64'(words_written), 64'd2);

`ifndef DDR_WRITER_WRAP_EN
        // Depth limit: three writes, the rest drained and discarded
        for (int i = 0; i < 6; i++) push(64'hC0 + 64'(i));
        b = cmd_n;
        pulse_start(30'h300, 27'd3);
        repeat (15) @(negedge clk);
        check("lim_ncmd", 64'(cmd_n - b), 64'd3);
        check("lim_a2", cmd_addr_log[(b + 2) % 64], 64'h310);
        check("lim_full", 64'(mem_full), 64'h1);
        check("lim_words", 64'(words_written), 64'd3);
        check("lim_drained", 64'(rd_ptr), 64'(wr_ptr));
        check("lim_busy", 64'(busy), 64'h1);
        pulse_done();
        check("lim_wdone", 64'(write_done), 64'h1);
        check("lim_words_done", 64'(words_written), 64'd3);
        check("lim_full_sticky", 64'(mem_full), 64'h1);
        @(negedge clk);
`else
        // Wrap: depth two from base 0x40 acts as a circular buffer
        for (int i = 0; i < 5; i++) push(64'hC0 + 64'(i));
        b = cmd_n;
        pulse_start(30'h40, 27'd2);
        wait_cmds(b + 5);
        repeat (2) @(negedge clk);
        check("wrap_ncmd", 64'(cmd_n - b), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("wrap_addr%0d", i), cmd_addr_log[(b + i) % 64], (i % 2 == 0) ? 64'h40 : 64'h48);
        check("wrap_full", 64'(mem_full), 64'h1);
        check("wrap_words", 64'(words_written), 64'd1);
        check("wrap_busy", 64'(busy), 64'h1);
`endif

        // Restart with a held word pending: word dropped, address reloaded
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        push(64'hD0);
        push(64'hD1);
        b  = cmd_n;
        bd = dat_n;
        pulse_start(30'h400, 27'd0);
        @(negedge clk);
        check("rs_held", 64'(app_en), 64'h1);
        check("rs_held_addr", 64'(app_addr), 64'h400);
        start_addr    = 30'h500;
        capture_start = 1'b1;
        #1 check("rs_nopop", 64'(fifo_rd), 64'h0);
        @(negedge clk);
        capture_start = 1'b0;
        check("rs_dropped", 64'(app_en), 64'h0);
        check("rs_addr", 64'(app_addr), 64'h500);
        check("rs_words", 64'(words_written), 64'd0);
        check("rs_full_clr", 64'(mem_full), 64'h0);
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        wait_cmds(b + 1);
        repeat (2) @(negedge clk);
        check("rs_ncmd", 64'(cmd_n - b), 64'd1);
        check("rs_a0", cmd_addr_log[b % 64], 64'h500);
        check("rs_d0", dat_log[bd % 64], 64'hD1);
        check("rs_ndat", 64'(dat_n - bd), 64'd1);

        // Simultaneous start and done: start wins, no completion pulse
        start_addr    = 30'h500;
        max_words     = 27'd0;
        capture_start = 1'b1;
        capture_done  = 1'b1;
        @(negedge clk);
        capture_start = 1'b0;
        capture_done  = 1'b0;
        check("sim_busy", 64'(busy), 64'h1);
        check("sim_wdone", 64'(write_done), 64'h0);
        check("sim_words", 64'(words_written), 64'd0);
        @(negedge clk);
        check("sim_wdone2", 64'(write_done), 64'h0);

        // Asynchronous reset in the middle of a transfer
        push(64'hE0);
        push(64'hE1);
        @(negedge clk);
        @(negedge clk);
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        @(negedge clk);
        check("ar_pending", 64'(app_en), 64'h1);
        check("ar_words_pre", 64'(words_written), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_en", 64'(app_en), 64'h0);
        check("ar_wren", 64'(app_wdf_wren), 64'h0);
        check("ar_addr", 64'(app_addr), 64'h0);
        check("ar_data", app_wdf_data, 64'h0);
        check("ar_words", 64'(words_written), 64'd0);
        check("ar_busy", 64'(busy), 64'h0);
        check("ar_fifo_rd", 64'(fifo_rd), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
